sha256_msg_loader: RTL and testbench

- Upstream feeder for the SHA-256 compression core.
- Accepts a message as a stream of big-endian 32-bit words with valid/ready handshake.
- Applies standard SHA-256 padding (0x80 marker, zero fill, 64-bit bit-length).
- Writes each 512-bit block into the core's 16-word input registers, pulses go, waits for done, repeats until the final block. Pulses msg_done when the digest on the core outputs is final.

---
 rtl/sha256_msg_loader.sv | 253 +++++++++++++++++++++++++
 tb/tb_sha256_msg_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_loader.sv
`default_nettype none
// ============================================================================
// Module  : sha256_msg_loader
// Brief   : Streams a big-endian message into the SHA-256 core's 16-word
//           input registers. Appends the 0x80 marker, zero fill and the
//           64-bit bit length, then runs one compression per 512-bit block.
//           Optional macro SHA_LOADER_STATS_EN adds the blk_count output,
//           which counts compressions started since the last core_reset.
// Revision: 1.0 - initial release
// ============================================================================
module sha256_msg_loader #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    output logic        core_reset,
    output logic        core_chipselect,
    output logic        core_write,
    output logic [3:0]  core_address,
    output logic [31:0] core_writedata,
    output logic        core_go,
    input  logic        core_done,
    output logic        msg_done,
    output logic        busy
`ifdef SHA_LOADER_STATS_EN
    ,
    output logic [15:0] blk_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_PAD  = 3'd2,
        S_LEN  = 3'd3,
        S_GO   = 3'd4,
        S_WAIT = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    localparam logic [31:0] c_MARKER_WORD = 32'h8000_0000;
    localparam logic [3:0]  c_LEN_HI_IDX  = 4'd14;
    localparam logic [3:0]  c_LAST_IDX    = 4'd15;

    state_t             r_state;
    logic [3:0]         r_idx;
    logic [LEN_W-1:0]   r_bitlen;
    logic               r_pad_done;   // 0x80 marker already written for this message
    logic               r_more_data;  // block full, message words still to come
    logic               r_extra_blk;  // padding spills into another block
    logic               r_final;      // block just issued carries the length
    logic               r_wait_first; // first WAIT cycle, core_done may be stale

    logic [2:0]         w_last_bytes;
    logic [2:0]         w_bytes;
    logic [31:0]        w_fmt_word;
    logic [63:0]        w_len64;
    logic               w_pad_skip;
    logic [LEN_W-1:0]   w_bit_add;

    // Zero-extend (or truncate) the internal bit counter to the 64-bit field.
    generate
        if (LEN_W < 64) begin : g_len_ext
            assign w_len64 = {{(64 - LEN_W){1'b0}}, r_bitlen};
        end else begin : g_len_trunc
            assign w_len64 = r_bitlen[63:0];
        end
    endgenerate

    // Out-of-range byte counts on the last word are treated as a full word.
    assign w_last_bytes = (in_bytes >= 3'd4) ? 3'd4 : in_bytes;
    assign w_bytes      = in_last ? w_last_bytes : 3'd4;
    assign w_bit_add    = LEN_W'({w_bytes, 3'b000});

    // In PAD, index 14 is left for the length once the marker is placed.
    assign w_pad_skip   = (r_state == S_PAD) && r_pad_done && (r_idx == c_LEN_HI_IDX);

    // Format the last word: keep the valid top bytes, insert the marker, zero the rest.
    always_comb begin
        w_fmt_word = in_data;
        if (in_last) begin
            case (w_last_bytes)
                3'd0:    w_fmt_word = c_MARKER_WORD;
                3'd1:    w_fmt_word = {in_data[31:24], 8'h80, 16'h0000};
                3'd2:    w_fmt_word = {in_data[31:16], 8'h80, 8'h00};
                3'd3:    w_fmt_word = {in_data[31:8], 8'h80};
                default: w_fmt_word = in_data;
            endcase
        end
    end

    // Decode core-side strobes and the upstream handshake from the current state.
    always_comb begin
        in_ready       = 1'b0;
        core_reset     = 1'b0;
        core_write     = 1'b0;
        core_address   = r_idx;
        core_writedata = 32'h0000_0000;
        core_go        = 1'b0;
        msg_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                core_reset = in_valid;
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    core_write     = 1'b1;
                    core_writedata = w_fmt_word;
                end
            end
            S_PAD: begin
                if (!w_pad_skip) begin
                    core_write     = 1'b1;
                    core_writedata = r_pad_done ? 32'h0000_0000 : c_MARKER_WORD;
                end
            end
            S_LEN: begin
                core_write     = 1'b1;
                core_writedata = (r_idx == c_LEN_HI_IDX) ? w_len64[63:32] : w_len64[31:0];
            end
            S_GO: begin
                core_go = 1'b1;
            end
            S_FIN: begin
                msg_done = 1'b1;
            end
            default: begin
                core_write = 1'b0;
            end
        endcase
    end

    assign core_chipselect = core_write;
    assign busy            = (r_state != S_IDLE);

    // Block sequencing: fill, pad, append length, compress, repeat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= 4'd0;
            r_bitlen     <= '0;
            r_pad_done   <= 1'b0;
            r_more_data  <= 1'b0;
            r_extra_blk  <= 1'b0;
            r_final      <= 1'b0;
            r_wait_first <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state     <= S_FILL;
                        r_idx       <= 4'd0;
                        r_bitlen    <= '0;
                        r_pad_done  <= 1'b0;
                        r_more_data <= 1'b0;
                        r_extra_blk <= 1'b0;
                        r_final     <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        r_bitlen <= r_bitlen + w_bit_add;
                        r_idx    <= r_idx + 4'd1;
                        if (in_last) begin
                            r_pad_done <= (w_last_bytes != 3'd4);
                            // A last word that fills the block leaves padding for the next one.
                            if (r_idx == c_LAST_IDX) begin
                                r_state     <= S_GO;
                                r_extra_blk <= 1'b1;
                            end else begin
                                r_state <= S_PAD;
                            end
                        end else if (r_idx == c_LAST_IDX) begin
                            r_state     <= S_GO;
                            r_more_data <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (w_pad_skip) begin
                        r_state <= S_LEN;
                    end else begin
                        r_pad_done <= 1'b1;
                        r_idx      <= r_idx + 4'd1;
                        if (r_idx == c_LAST_IDX) begin
                            r_state     <= S_GO;
                            r_extra_blk <= 1'b1;
                        end
                    end
                end
                S_LEN: begin
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= S_GO;
                        r_final <= 1'b1;
                    end
                end
                S_GO: begin
                    r_state      <= S_WAIT;
                    r_wait_first <= 1'b1;
                end
                S_WAIT: begin
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (core_done) begin
                        r_idx       <= 4'd0;
                        r_more_data <= 1'b0;
                        r_extra_blk <= 1'b0;
                        r_final     <= 1'b0;
                        if (r_final) begin
                            r_state <= S_FIN;
                        end else if (r_extra_blk) begin
                            r_state <= S_PAD;
                        end else if (r_more_data) begin
                            r_state <= S_FILL;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SHA_LOADER_STATS_EN
    logic [15:0] r_blk_count;

    // Count compressions started for the current message, saturating.
    always_ff @(posedge clk) begin
        if (reset || core_reset) begin
            r_blk_count <= 16'h0000;
        end else if (core_go && (r_blk_count != 16'hFFFF)) begin
            r_blk_count <= r_blk_count + 16'h0001;
        end
    end

    assign blk_count = r_blk_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_sha256_msg_loader
// Brief   : Self-checking bench for sha256_msg_loader. Expected block words
//           come from a byte-level padding model; a simple core model
//           answers core_go with a delayed, level core_done.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sha256_msg_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        in_last = 1'b0;
    logic [2:0]  in_bytes = 3'd0;
    logic        core_reset;
    logic        core_chipselect;
    logic        core_write;
    logic [3:0]  core_address;
    logic [31:0] core_writedata;
    logic        core_go;
    logic        core_done = 1'b1;
    logic        msg_done;
    logic        busy;
`ifdef SHA_LOADER_STATS_EN
    logic [15:0] blk_count;
`endif

    sha256_msg_loader #(.LEN_W(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_last         (in_last),
        .in_bytes        (in_bytes),
        .core_reset      (core_reset),
        .core_chipselect (core_chipselect),
        .core_write      (core_write),
        .core_address    (core_address),
        .core_writedata  (core_writedata),
        .core_go         (core_go),
        .core_done       (core_done),
        .msg_done        (msg_done),
        .busy            (busy)
`ifdef SHA_LOADER_STATS_EN
        ,
        .blk_count       (blk_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];     // expected write stream, in order
    logic [31:0] cap_all[$];   // words actually written for the current message
    logic [31:0] st_data[$];   // stimulus words of the current message
    int          st_nfull;
    int          st_lastb;
    int          wr_cnt;
    int          go_cnt;
    int          done_cnt = 0;
    int          exp_blocks;
    logic        core_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Build stimulus and the padded-message model: bytes, 0x80, zeros to 56 mod 64, 64-bit length.
    task automatic prep_msg(input int nfull, input int lastb, input logic [31:0] ovr, input bit use_ovr);
        logic [7:0]  b[$];
        logic [31:0] w;
        logic [63:0] nbits;
        int          len;
        st_data.delete();
        for (int i = 0; i < nfull; i++) begin
            w = $urandom;
            st_data.push_back(w);
            for (int j = 3; j >= 0; j--) b.push_back(w[j*8 +: 8]);
        end
        w = use_ovr ? ovr : $urandom;
        st_data.push_back(w);
        for (int j = 0; j < lastb; j++) b.push_back(w[(3-j)*8 +: 8]);
        len   = b.size();
        nbits = 64'(len) * 64'd8;
        b.push_back(8'h80);
        while ((b.size() % 64) != 56) b.push_back(8'h00);
        for (int j = 7; j >= 0; j--) b.push_back(nbits[j*8 +: 8]);
        exp_q.delete();
        for (int i = 0; i < b.size() / 4; i++)
            exp_q.push_back({b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]});
        exp_blocks = b.size() / 64;
        st_nfull   = nfull;
        st_lastb   = lastb;
        wr_cnt     = 0;
        go_cnt     = 0;
        cap_all.delete();
    endtask

    // mode 0: back-to-back, 1: idle cycle before every 3rd word, 2: random idle cycles
    task automatic drive_msg(input int mode);
        int  n;
        bit  got;
        for (int i = 0; i <= st_nfull; i++) begin
            if ((mode == 1 && (i % 3) == 2) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = st_data[i];
            in_last  = (i == st_nfull);
            in_bytes = (i == st_nfull) ? 3'(st_lastb) : 3'($urandom_range(0, 7));
            n   = 0;
            got = 1'b0;
            while (!got && n < 200) begin
                @(negedge clk);
                if (in_ready) got = 1'b1;
                n++;
            end
            if (!got) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: word %0d not accepted, required within 200 cycles", i);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        int base = done_cnt;
        while (done_cnt == base && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("msg_done_seen", 64'(done_cnt - base), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Core model: done drops two cycles after go (so a stale done is visible
    // in the first WAIT cycle), then rises again after a random delay.
    initial begin
        forever begin
            @(negedge clk);
            if (core_go && !reset) begin
                core_busy = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1 core_done = 1'b0;
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1 core_done = 1'b1;
                core_busy = 1'b0;
            end
        end
    end

    // Scoreboard: every write, go and done pulse against the padding model.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            if (core_write) begin
                check("wr_cs", 64'(core_chipselect), 64'd1);
                check("wr_go_overlap", 64'(core_go), 64'd0);
                check("wr_core_idle", 64'(core_busy), 64'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_extra: write addr=%0d data=%h, required no write", core_address, core_writedata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(core_address), 64'(wr_cnt % 16));
                    check("wr_data", 64'(core_writedata), 64'(e));
                end
                cap_all.push_back(core_writedata);
                wr_cnt++;
            end
            if (core_go) begin
                check("go_after_16", 64'(wr_cnt), 64'((go_cnt + 1) * 16));
                go_cnt++;
            end
            if (msg_done) begin
                check("done_blocks", 64'(go_cnt), 64'(exp_blocks));
                check("done_q_empty", 64'(exp_q.size()), 64'd0);
                check("done_core_idle", 64'(core_busy), 64'd0);
                done_cnt++;
            end
            if (core_reset) check("core_reset_idle", 64'(busy), 64'd0);
            if (!busy) check("ready_idle", 64'(in_ready), 64'd0);
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_outs"}, 64'({in_ready, core_reset, core_chipselect, core_write,
                                   core_go, msg_done}), 64'd0);
        check({tag, "_addr_data"}, 64'({core_address, core_writedata}), 64'd0);
    endtask

    initial begin
        int base;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
`ifdef SHA_LOADER_STATS_EN
        check("reset_blk_count", 64'(blk_count), 64'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // "abc"
        prep_msg(0, 3, 32'h6162_6300, 1'b1);
        drive_msg(0);
        wait_done();
        check("abc_w0", 64'(cap_all[0]), 64'h6162_6380);
        check("abc_w1", 64'(cap_all[1]), 64'h0);
        check("abc_w15", 64'(cap_all[15]), 64'h18);
        check("abc_gos", 64'(go_cnt), 64'd1);

        // empty message
        prep_msg(0, 0, 32'h0, 1'b0);
        drive_msg(0);
        wait_done();
        check("empty_w0", 64'(cap_all[0]), 64'h8000_0000);
        check("empty_w15", 64'(cap_all[15]), 64'h0);
        check("empty_gos", 64'(go_cnt), 64'd1);

        // 55 bytes
        prep_msg(13, 3, 32'h0, 1'b0);
        drive_msg(0);
        wait_done();
        check("b55_w13_lo", 64'(cap_all[13][7:0]), 64'h80);
        check("b55_w14", 64'(cap_all[14]), 64'h0);
        check("b55_w15", 64'(cap_all[15]), 64'h1B8);
        check("b55_gos", 64'(go_cnt), 64'd1);

        // 56 bytes
        prep_msg(13, 4, 32'h0, 1'b0);
        drive_msg(0);
        wait_done();
        check("b56_w14", 64'(cap_all[14]), 64'h8000_0000);
        check("b56_w15", 64'(cap_all[15]), 64'h0);
        check("b56_b2w0", 64'(cap_all[16]), 64'h0);
        check("b56_b2w15", 64'(cap_all[31]), 64'h1C0);
        check("b56_gos", 64'(go_cnt), 64'd2);

        // 64 bytes with gaps
        prep_msg(15, 4, 32'h0, 1'b0);
        drive_msg(1);
        wait_done();
        check("b64_b2w0", 64'(cap_all[16]), 64'h8000_0000);
        check("b64_b2w15", 64'(cap_all[31]), 64'h200);
        check("b64_gos", 64'(go_cnt), 64'd2);
`ifdef SHA_LOADER_STATS_EN
        check("b64_blk_count", 64'(blk_count), 64'd2);
`endif

        // reset while waiting on the core
        prep_msg(0, 3, 32'h6162_6300, 1'b1);
        drive_msg(0);
        n = 0;
        while (go_cnt == 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("rst_go_seen", 64'(go_cnt), 64'd1);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_quiet("rst_wait");
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        base = done_cnt;
        repeat (15) @(posedge clk);
        #1;
        check("rst_no_done", 64'(done_cnt), 64'(base));
        prep_msg(0, 3, 32'h6162_6300, 1'b1);
        drive_msg(0);
        wait_done();
        check("rst_abc_w0", 64'(cap_all[0]), 64'h6162_6380);
        check("rst_abc_w15", 64'(cap_all[15]), 64'h18);
        check("rst_abc_gos", 64'(go_cnt), 64'd1);

        // randomized messages
        for (int m = 0; m < 12; m++) begin
            prep_msg($urandom_range(0, 35), $urandom_range(0, 4), 32'h0, 1'b0);
            drive_msg(2);
            wait_done();
`ifdef SHA_LOADER_STATS_EN
            check("rand_blk_count", 64'(blk_count), 64'(exp_blocks));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
